imm_packer: RTL and testbench

Inverse of the core's immediate extender: takes a 32-bit immediate, an `Ext_Imm*` format code and a base instruction word, and scatters the immediate into the RISC-V I/S/B/U/J bit positions, leaving all other bits from the base word. It is a two-stage valid/ready pipeline used by the instruction injector and self-test generator to build or patch instructions. It also flags immediates that cannot be represented in the chosen format and keeps a saturating error count.

---
 rtl/imm_packer.sv | 150 +++++++++++++++
 tb/tb_imm_packer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_packer.sv
// rtl/imm_packer.sv - scatters an immediate into RISC-V I/S/B/U/J instruction fields
// Two-stage valid/ready pipeline with representability check and saturating error count.
module imm_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_sel,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  // Format codes, matching the core's Ext_Imm* encoding.
  localparam logic [2:0] EXT_IMM_I = 3'd0;
  localparam logic [2:0] EXT_IMM_S = 3'd1;
  localparam logic [2:0] EXT_IMM_B = 3'd2;
  localparam logic [2:0] EXT_IMM_U = 3'd3;
  localparam logic [2:0] EXT_IMM_J = 3'd4;

  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_sel_q,   s1_sel_d;
  logic [31:0] s1_imm_q,   s1_imm_d;
  logic [31:0] s1_base_q,  s1_base_d;
  logic        s1_err_q,   s1_err_d;

  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_ins_q,   s2_ins_d;
  logic        s2_err_q,   s2_err_d;

  logic [7:0]  err_cnt_q,  err_cnt_d;

  logic        in_fire;
  logic        out_fire;
  logic        s2_load;
  logic        imm_err;
  logic [31:0] packed_ins;

  assign in_ready  = rst_n && (!s1_valid_q || !s2_valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = s2_valid_q && out_ready;
  assign s2_load   = s1_valid_q && (!s2_valid_q || out_ready);

  assign out_valid = s2_valid_q;
  assign out_ins   = s2_ins_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;

  // A field fits when every bit above its sign position repeats the sign.
  always_comb begin
    imm_err = 1'b1;
    case (in_sel)
      EXT_IMM_I,
      EXT_IMM_S: imm_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      EXT_IMM_B: imm_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      EXT_IMM_J: imm_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      EXT_IMM_U: imm_err = |in_imm[11:0];
      default:   imm_err = 1'b1;
    endcase
  end

  always_comb begin
    packed_ins = s1_base_q;
    case (s1_sel_q)
      EXT_IMM_I: packed_ins[31:20] = s1_imm_q[11:0];
      EXT_IMM_S: begin
        packed_ins[31:25] = s1_imm_q[11:5];
        packed_ins[11:7]  = s1_imm_q[4:0];
      end
      EXT_IMM_B: begin
        packed_ins[31]    = s1_imm_q[12];
        packed_ins[7]     = s1_imm_q[11];
        packed_ins[30:25] = s1_imm_q[10:5];
        packed_ins[11:8]  = s1_imm_q[4:1];
      end
      EXT_IMM_U: packed_ins[31:12] = s1_imm_q[31:12];
      EXT_IMM_J: begin
        packed_ins[31]    = s1_imm_q[20];
        packed_ins[30:21] = s1_imm_q[10:1];
        packed_ins[20]    = s1_imm_q[11];
        packed_ins[19:12] = s1_imm_q[19:12];
      end
      default: packed_ins = s1_base_q;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sel_d   = s1_sel_q;
    s1_imm_d   = s1_imm_q;
    s1_base_d  = s1_base_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_ins_d   = s2_ins_q;
    s2_err_d   = s2_err_q;
    err_cnt_d  = err_cnt_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_sel_d   = in_sel;
      s1_imm_d   = in_imm;
      s1_base_d  = in_base;
      s1_err_d   = imm_err;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // Stage 2 holds its word until the consumer takes it, so a stall freezes out_*.
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_ins_d   = packed_ins;
      s2_err_d   = s1_err_q;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    if (out_fire && s2_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= 3'd0;
      s1_imm_q   <= 32'd0;
      s1_base_q  <= 32'd0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_ins_q   <= 32'd0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sel_q   <= s1_sel_d;
      s1_imm_q   <= s1_imm_d;
      s1_base_q  <= s1_base_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_ins_q   <= s2_ins_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_packer.sv
// tb/tb_imm_packer.sv - self-checking bench for imm_packer
// Reference model: field arithmetic for packing, signed ranges for errors, decoder for round trip.
module tb_imm_packer;

  localparam logic [2:0] SEL_I = 3'd0;
  localparam logic [2:0] SEL_S = 3'd1;
  localparam logic [2:0] SEL_B = 3'd2;
  localparam logic [2:0] SEL_U = 3'd3;
  localparam logic [2:0] SEL_J = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic        out_err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  imm_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ins   (out_ins),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] base;
    longint      cyc;
  } entry_t;

  entry_t q[$];
  longint cyc = 0;
  int     model_cnt = 0;
  int     pops = 0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  function automatic logic [31:0] pack_m(input logic [2:0] sel, input logic [31:0] imm,
                                         input logic [31:0] base);
    case (sel)
      SEL_I: return (base & 32'h000F_FFFF) | (imm << 20);
      SEL_S: return (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      SEL_B: return (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                    | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 32'h1) << 7);
      SEL_U: return (base & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
      SEL_J: return (base & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
                    | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                    | (imm & 32'h000F_F000);
      default: return base;
    endcase
  endfunction

  function automatic logic err_m(input logic [2:0] sel, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (sel)
      SEL_I, SEL_S: return !(s >= -2048 && s <= 2047);
      SEL_B:        return !(s >= -4096 && s <= 4095) || ((imm % 2) != 0);
      SEL_J:        return !(s >= -1048576 && s <= 1048575) || ((imm % 2) != 0);
      SEL_U:        return (imm % 4096) != 0;
      default:      return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] sel, input logic [31:0] ins);
    case (sel)
      SEL_I: return {{20{ins[31]}}, ins[31:20]};
      SEL_S: return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      SEL_B: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      SEL_U: return {ins[31:12], 12'b0};
      SEL_J: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  // Inputs change only #1 after a rising edge, so negedge samples equal the next edge's view.
  always @(negedge clk) begin
    entry_t e;
    logic   exp_valid;
    if (!rst_n) begin
      chk("in_ready_in_reset", in_ready, 1'b0);
      q.delete();
      model_cnt = 0;
    end else begin
      exp_valid = (q.size() > 0) && (q[0].cyc + 1 < cyc);
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("err_cnt", err_cnt, model_cnt);
      if (exp_valid && out_valid) begin
        e = q[0];
        chk("out_ins", out_ins, pack_m(e.sel, e.imm, e.base));
        chk("out_err", out_err, err_m(e.sel, e.imm));
        if (!out_err) begin
          chk("round_trip", extend(e.sel, out_ins), e.imm);
          chk("opcode_kept", out_ins & 32'h7F, e.base & 32'h7F);
        end
        if (out_ready) begin
          void'(q.pop_front());
          pops++;
          if (err_m(e.sel, e.imm) && model_cnt < 255) model_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        e.sel  = in_sel;
        e.imm  = in_imm;
        e.base = in_base;
        e.cyc  = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    logic ok;
    ok       = 1'b0;
    in_sel   = sel;
    in_imm   = imm;
    in_base  = base;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) timeout("send");
  endtask

  task automatic rand_word(output logic [2:0] sel, output logic [31:0] imm, output logic [31:0] base);
    logic [31:0] r;
    r    = $urandom;
    base = $urandom;
    sel  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    if ($urandom_range(0, 1) == 0) begin
      imm = $urandom;
    end else begin
      case (sel)
        SEL_I, SEL_S: imm = {{20{r[11]}}, r[11:0]};
        SEL_B:        imm = {{19{r[12]}}, r[12:1], 1'b0};
        SEL_J:        imm = {{11{r[20]}}, r[20:1], 1'b0};
        SEL_U:        imm = {r[31:12], 12'b0};
        default:      imm = r;
      endcase
    end
  endtask

  initial begin
    logic        fire;
    logic [2:0]  ws [3];
    logic [31:0] wi [3];
    logic [31:0] wb [3];
    int          acc;
    int          idx;
    int          p0;
    int          n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_imm    = 32'd0;
    in_base   = 32'd0;
    out_ready = 1'b1;

    chk("model_pack_I", pack_m(SEL_I, 32'hFFFF_F800, 32'h13), 32'h8000_0013);
    chk("model_pack_B", pack_m(SEL_B, 32'h0000_0FFE, 32'h63), 32'h7E00_0FE3);
    chk("model_pack_U", pack_m(SEL_U, 32'h1234_5000, 32'hB7), 32'h1234_50B7);
    chk("model_err_B",  err_m(SEL_B, 32'h0000_1000), 1'b1);
    chk("model_err_J",  err_m(SEL_J, 32'h0000_0001), 1'b1);
    chk("model_err_U",  err_m(SEL_U, 32'h1234_5001), 1'b1);
    chk("model_ok_I",   err_m(SEL_I, 32'hFFFF_F800), 1'b0);

    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_ins",   out_ins,   32'd0);
    chk("reset_out_err",   out_err,   1'b0);
    chk("reset_err_cnt",   err_cnt,   8'd0);

    in_sel   = SEL_I;
    in_imm   = 32'hFFFF_F800;
    in_base  = 32'h0000_0013;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_not_yet", out_valid, 1'b0);
    tick();
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_ins",   out_ins,   32'h8000_0013);
    chk("lat_err",   out_err,   1'b0);

    send(SEL_B, 32'h0000_0FFE, 32'h0000_0063);
    tick();
    chk("B_ins", out_ins, 32'h7E00_0FE3);
    chk("B_err", out_err, 1'b0);
    send(SEL_B, 32'h0000_1000, 32'h0000_0063);
    tick();
    chk("B_bad_err", out_err, 1'b1);
    repeat (2) tick();
    chk("err_cnt_1", err_cnt, 8'd1);
    send(SEL_J, 32'h0000_0001, 32'h0000_006F);
    repeat (3) tick();
    chk("err_cnt_2", err_cnt, 8'd2);
    send(SEL_U, 32'h1234_5000, 32'h0000_00B7);
    tick();
    chk("U_ins", out_ins, 32'h1234_50B7);
    chk("U_err", out_err, 1'b0);
    send(SEL_U, 32'h1234_5001, 32'h0000_00B7);
    tick();
    chk("U_bad_err", out_err, 1'b1);
    repeat (2) tick();

    for (int i = 0; i < 3; i++) begin
      ws[i] = SEL_I;
      wi[i] = 32'($urandom_range(0, 2047));
      wb[i] = $urandom;
    end
    out_ready = 1'b0;
    acc       = 0;
    idx       = 0;
    in_sel    = ws[0];
    in_imm    = wi[0];
    in_base   = wb[0];
    in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      fire = in_ready;
      tick();
      if (fire) begin
        acc++;
        idx++;
        if (idx < 3) begin
          in_sel  = ws[idx];
          in_imm  = wi[idx];
          in_base = wb[idx];
        end
      end
    end
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_hold_ins", out_ins, pack_m(ws[0], wi[0], wb[0]));
    p0        = pops;
    out_ready = 1'b1;
    @(negedge clk);
    fire = in_ready;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("bp_third_accepted", fire, 1'b1);
    chk("bp_drain_per_cycle", pops - p0, 3);
    chk("bp_drained", out_valid, 1'b0);

    in_sel   = 3'b111;
    in_base  = $urandom;
    in_valid = 1'b1;
    acc      = 0;
    for (int c = 0; c < 2000 && acc < 300; c++) begin
      @(negedge clk);
      fire = in_ready;
      tick();
      in_imm = $urandom;
      if (fire) acc++;
    end
    in_valid = 1'b0;
    if (acc < 300) timeout("saturation_feed");
    repeat (4) tick();
    chk("err_cnt_sat", err_cnt, 8'd255);
    send(3'b111, 32'h0, 32'h0);
    repeat (4) tick();
    chk("err_cnt_hold", err_cnt, 8'd255);

    out_ready = 1'b0;
    send(SEL_I, 32'd5, 32'h13);
    send(SEL_S, 32'd6, 32'h23);
    chk("full_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_reset_out_valid", out_valid, 1'b0);
    chk("mid_reset_out_ins",   out_ins,   32'd0);
    chk("mid_reset_err_cnt",   err_cnt,   8'd0);
    out_ready = 1'b1;
    in_sel    = SEL_S;
    in_imm    = 32'hFFFF_FFFF;
    in_base   = 32'h0000_0023;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("recover_not_yet", out_valid, 1'b0);
    tick();
    chk("recover_valid", out_valid, 1'b1);
    chk("recover_ins",   out_ins,   pack_m(SEL_S, 32'hFFFF_FFFF, 32'h23));
    tick();

    n    = 0;
    fire = 1'b0;
    for (int c = 0; c < 60000 && n < 10000; c++) begin
      if (!in_valid || fire) begin
        rand_word(in_sel, in_imm, in_base);
        in_valid = ($urandom_range(0, 4) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      fire = in_valid && in_ready;
      tick();
      if (fire) n++;
    end
    in_valid = 1'b0;
    if (n < 10000) timeout("random_feed");
    out_ready = 1'b1;
    repeat (5) tick();
    chk("random_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
